// File: rtl/pubexp_select_ctrl_if.sv
// pubexp_select_ctrl_if: sequencer, RNG and gcd signals of the public-exponent selector
// master: key-gen sequencer plus RNG/gcd side (drives start/phi/rng_data/gcd_done/gcd_result)
// slave: pubexp_select_ctrl (drives busy/done/fail/e_out/attempts/rng_en/gcd_start/gcd_a/gcd_b)
interface pubexp_select_ctrl_if #(
  parameter int WIDTH     = 32,
  parameter int MAX_TRIES = 64
);
  localparam int CW = $clog2(MAX_TRIES + 1);
  logic             start;
  logic [WIDTH-1:0] phi;
  logic             busy;
  logic             done;
  logic             fail;
  logic [WIDTH-1:0] e_out;
  logic [CW-1:0]    attempts;
  logic             rng_en;
  logic [WIDTH-1:0] rng_data;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  modport master (
    output start, phi, rng_data, gcd_done, gcd_result,
    input  busy, done, fail, e_out, attempts, rng_en, gcd_start, gcd_a, gcd_b
  );
  modport slave (
    input  start, phi, rng_data, gcd_done, gcd_result,
    output busy, done, fail, e_out, attempts, rng_en, gcd_start, gcd_a, gcd_b
  );
endinterface

// File: rtl/pubexp_select_ctrl.sv
// pubexp_select_ctrl: draws RNG candidates, filters them against phi and accepts the first with gcd(e, phi) = 1
// ports: clk, rst (sync, active-high); bus = pubexp_select_ctrl_if.slave
//   (start/phi/busy/done/fail/e_out/attempts, rng_en/rng_data, gcd_start/gcd_a/gcd_b/gcd_done/gcd_result)
// PUBEXP_FORCE_ODD_EN: when defined, sampled draws are forced odd instead of even ones being rejected
module pubexp_select_ctrl #(
  parameter int WIDTH     = 32,
  parameter int MAX_TRIES = 64
) (
  input logic                 clk,
  input logic                 rst,
  pubexp_select_ctrl_if.slave bus
);
  localparam int CW = $clog2(MAX_TRIES + 1);
  typedef enum logic [2:0] {IDLE, DRAW, SAMPLE, CHECK, GCD_REQ, GCD_WAIT, FINISH} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] phi_q;
  logic [WIDTH-1:0] cand;
  logic             ok;
  logic             last;
  logic             cand_ok;
  logic             coprime;
  assign last    = bus.attempts == CW'(MAX_TRIES);
  assign cand_ok = cand >= WIDTH'(3) && cand < phi_q && cand[0];
  assign coprime = bus.gcd_result == WIDTH'(1);
  always_comb begin
    state_n       = state;
    bus.busy      = state != IDLE;
    bus.rng_en    = state == DRAW;
    bus.gcd_start = state == GCD_REQ;
    bus.done      = state == FINISH && ok;
    bus.fail      = state == FINISH && !ok;
    bus.gcd_a     = cand;
    bus.gcd_b     = phi_q;
    case (state)
      IDLE:     if (bus.start) state_n = bus.phi < WIDTH'(4) ? FINISH : DRAW;
      DRAW:     state_n = SAMPLE;
      SAMPLE:   state_n = CHECK;
      CHECK:    state_n = cand_ok ? GCD_REQ : last ? FINISH : DRAW;
      GCD_REQ:  state_n = GCD_WAIT;
      GCD_WAIT: if (bus.gcd_done) state_n = coprime || last ? FINISH : DRAW;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phi_q        <= '0;
      cand         <= '0;
      ok           <= 1'b0;
      bus.e_out    <= '0;
      bus.attempts <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        phi_q        <= bus.phi;
        ok           <= 1'b0;
        bus.e_out    <= '0;
        bus.attempts <= '0;
      end
      if (state == DRAW) bus.attempts <= bus.attempts + CW'(1);
`ifdef PUBEXP_FORCE_ODD_EN
      if (state == SAMPLE) cand <= bus.rng_data | WIDTH'(1);
`else
      if (state == SAMPLE) cand <= bus.rng_data;
`endif
      if (state == GCD_WAIT && bus.gcd_done && coprime) begin
        ok        <= 1'b1;
        bus.e_out <= cand;
      end
    end
  end
endmodule

// File: tb/tb_pubexp_select_ctrl.sv
// tb_pubexp_select_ctrl: scoreboard bench with mock RNG and gcd unit for pubexp_select_ctrl
module tb_pubexp_select_ctrl;
  localparam int WIDTH     = 32;
  localparam int MAX_TRIES = 64;
  localparam int CW        = $clog2(MAX_TRIES + 1);
  localparam logic [WIDTH-1:0] BIG_PHI = 32'd4157295846;
  typedef struct {
    logic             ok;
    logic [WIDTH-1:0] e;
    logic [CW-1:0]    att;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pubexp_select_ctrl_if #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES)) bus ();
  pubexp_select_ctrl #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t             exp_q[$];
  logic [WIDTH-1:0] rng_q[$];
  logic [WIDTH-1:0] res_q[$];
  logic [WIDTH-1:0] cand_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, resp_cnt = 0, rng_cnt = 0, gcd_cnt = 0, busy_cnt = 0;
  int start_cyc = 0, done_cyc = 0, gdone_cyc = 0, gcd_delay = 1, cnt = 0;
  logic pend = 1'b0, inflight = 1'b0, unstable = 1'b0, prev_rng = 1'b0;
  logic [WIDTH-1:0] cur_phi = '0, cap_a = '0, cap_b = '0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rng_en) bus.rng_data <= rng_q.size() != 0 ? rng_q.pop_front() : '0;
  end
  always @(posedge clk) begin
    bus.gcd_done <= 1'b0;
    if (bus.gcd_start) begin
      if (gcd_delay == 1) begin
        bus.gcd_done   <= 1'b1;
        bus.gcd_result <= res_q.size() != 0 ? res_q.pop_front() : '0;
      end else begin
        pend <= 1'b1;
        cnt  <= gcd_delay - 1;
      end
    end else if (pend) begin
      if (cnt == 1) begin
        pend           <= 1'b0;
        bus.gcd_done   <= 1'b1;
        bus.gcd_result <= res_q.size() != 0 ? res_q.pop_front() : '0;
      end else cnt <= cnt - 1;
    end
  end
  always @(negedge clk) begin
    exp_t x;
    if (rst) inflight = 1'b0;
    if (bus.busy) busy_cnt++;
    if (bus.rng_en) begin
      rng_cnt++;
      check("rng_en_back_to_back", prev_rng, 0);
    end
    prev_rng = bus.rng_en;
    if (bus.gcd_start) begin
      gcd_cnt++;
      check("gcd_start_while_waiting", inflight, 0);
      check("gcd_a", bus.gcd_a, cand_q.size() != 0 ? 64'(cand_q.pop_front()) : '1);
      check("gcd_b", bus.gcd_b, cur_phi);
      cap_a    = bus.gcd_a;
      cap_b    = bus.gcd_b;
      inflight = 1'b1;
      unstable = 1'b0;
    end else if (inflight && (bus.gcd_a !== cap_a || bus.gcd_b !== cap_b)) unstable = 1'b1;
    if (bus.gcd_done && !rst) begin
      gdone_cyc = cyc;
      if (inflight) check("gcd_ab_stable", unstable, 0);
      inflight = 1'b0;
    end
    if (bus.done || bus.fail) begin
      resp_cnt++;
      done_cyc = cyc;
      check("done_fail_exclusive", bus.done && bus.fail, 0);
      if (exp_q.size() == 0) check("unexpected_response", exp_q.size(), 1);
      else begin
        x = exp_q.pop_front();
        check("done", bus.done, x.ok);
        check("fail", bus.fail, !x.ok);
        if (x.ok) check("e_out", bus.e_out, x.e);
        check("attempts", bus.attempts, x.att);
      end
    end
  end
  task automatic expect_resp(input logic ok, input logic [WIDTH-1:0] e, input int att);
    exp_t x;
    x.ok  = ok;
    x.e   = e;
    x.att = CW'(att);
    exp_q.push_back(x);
  endtask
  task automatic go(input logic [WIDTH-1:0] p);
    @(posedge clk);
    #1;
    bus.phi   = p;
    cur_phi   = p;
    bus.start = 1'b1;
    start_cyc = cyc;
    rng_cnt   = 0;
    gcd_cnt   = 0;
    busy_cnt  = 0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.phi   = '0;
  endtask
  task automatic wait_resp(input int r0, input int budget, input string name);
    for (int i = 0; i < budget && resp_cnt == r0; i++) @(posedge clk);
    check({name, "_responses"}, resp_cnt - r0, 1);
  endtask
  task automatic pulse_start();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.phi   = 32'd1000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.phi   = '0;
  endtask
  initial begin
    int r0;
    bus.start = 1'b0;
    bus.phi   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_e_out", bus.e_out, 0);
    check("rst_attempts", bus.attempts, 0);
    check("rst_rng_en", bus.rng_en, 0);
    check("rst_gcd_start", bus.gcd_start, 0);
    // minimum latency, plus a start held during the FINISH cycle
    r0 = resp_cnt;
    rng_q = '{32'd65537};
    res_q = '{32'd1};
    cand_q = '{32'd65537};
    expect_resp(1, 32'd65537, 1);
    go(BIG_PHI);
    repeat (4) @(posedge clk);
    pulse_start();
    repeat (20) @(posedge clk);
    check("minlat_responses", resp_cnt - r0, 1);
    check("minlat_done_cycle", done_cyc - start_cyc, 6);
    check("minlat_gcd_done_cycle", gdone_cyc - start_cyc, 5);
    check("minlat_busy_cycles", busy_cnt, 6);
    check("minlat_rng_pulses", rng_cnt, 1);
    // filter rejections then gcd rejection then accept
    r0 = resp_cnt;
    rng_q = '{32'd10, 32'd4157295900, 32'd15, 32'd65537};
    res_q = '{32'd3, 32'd1};
    cand_q = '{32'd15, 32'd65537};
    expect_resp(1, 32'd65537, 4);
    go(BIG_PHI);
    wait_resp(r0, 200, "main");
    check("main_rng_pulses", rng_cnt, 4);
    check("main_gcd_starts", gcd_cnt, 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("main_e_out_held", bus.e_out, 65537);
    check("main_attempts_held", bus.attempts, 4);
    check("main_busy_low", bus.busy, 0);
    // phi below 4 fails immediately without touching RNG or gcd
    r0 = resp_cnt;
    expect_resp(0, 0, 0);
    go(32'd3);
    wait_resp(r0, 20, "small_phi");
    check("small_phi_fail_cycle", done_cyc - start_cyc, 1);
    check("small_phi_rng_pulses", rng_cnt, 0);
    check("small_phi_gcd_starts", gcd_cnt, 0);
    // phi = 4 is accepted and 3 is the smallest valid candidate
    r0 = resp_cnt;
    rng_q = '{32'd3};
    res_q = '{32'd1};
    cand_q = '{32'd3};
    expect_resp(1, 32'd3, 1);
    go(32'd4);
    wait_resp(r0, 50, "phi4");
    // range edges: 1 too small, 11 equal to phi, 13 above phi
    r0 = resp_cnt;
    rng_q = '{32'd1, 32'd11, 32'd13, 32'd3};
    res_q = '{32'd1};
    cand_q = '{32'd3};
    expect_resp(1, 32'd3, 4);
    go(32'd11);
    wait_resp(r0, 100, "range");
    check("range_gcd_starts", gcd_cnt, 1);
    // every gcd rejects: fail on the last attempt
    r0 = resp_cnt;
    rng_q.delete();
    res_q.delete();
    cand_q.delete();
    for (int i = 0; i < MAX_TRIES; i++) begin
      rng_q.push_back(32'd7);
      res_q.push_back(32'd2);
      cand_q.push_back(32'd7);
    end
    expect_resp(0, 0, MAX_TRIES);
    go(32'd1000);
    wait_resp(r0, 2000, "gcd_exhaust");
    check("gcd_exhaust_rng_pulses", rng_cnt, MAX_TRIES);
    check("gcd_exhaust_gcd_starts", gcd_cnt, MAX_TRIES);
    // every draw even: fail from the filter on the last attempt
    r0 = resp_cnt;
    rng_q.delete();
    for (int i = 0; i < MAX_TRIES; i++) rng_q.push_back(32'd8);
    expect_resp(0, 0, MAX_TRIES);
    go(32'd1000);
    wait_resp(r0, 2000, "even_exhaust");
    check("even_exhaust_rng_pulses", rng_cnt, MAX_TRIES);
    check("even_exhaust_gcd_starts", gcd_cnt, 0);
    // slow gcd with a stray start while waiting
    r0 = resp_cnt;
    gcd_delay = 20;
    rng_q = '{32'd65537};
    res_q = '{32'd1};
    cand_q = '{32'd65537};
    expect_resp(1, 32'd65537, 1);
    go(BIG_PHI);
    repeat (8) @(posedge clk);
    pulse_start();
    wait_resp(r0, 100, "slow_gcd");
    check("slow_gcd_done_after_gcd_done", done_cyc - gdone_cyc, 1);
    repeat (10) @(posedge clk);
    check("slow_gcd_no_restart", resp_cnt - r0, 1);
    // reset while waiting on gcd; the late gcd_done must be ignored
    r0 = resp_cnt;
    gcd_delay = 6;
    rng_q = '{32'd65537};
    res_q = '{32'd1};
    cand_q = '{32'd65537};
    go(BIG_PHI);
    for (int i = 0; i < 20 && gcd_cnt == 0; i++) @(posedge clk);
    check("rst_run_gcd_starts", gcd_cnt, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_rng_en", bus.rng_en, 0);
    check("midrst_gcd_start", bus.gcd_start, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midrst_no_response", resp_cnt - r0, 0);
    check("midrst_busy_late", bus.busy, 0);
    check("midrst_e_out", bus.e_out, 0);
    check("midrst_attempts", bus.attempts, 0);
    check("midrst_rng_late", rng_cnt, 1);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pubexp_select_ctrl.md
# pubexp_select_ctrl

Controller that picks the RSA public exponent e. It draws candidates from the 32-bit RNG (rng_out updates on the clock edge where en is high) and screens each one against phi. Surviving candidates go to the shared gcd datapath, and the first candidate with gcd(e, phi) = 1 is accepted. It sits between the top-level key-generation sequencer and the RNG/gcd blocks, and owns both their enables for the whole selection.

## Interface
- WIDTH, 32, operand width of phi, candidate and e.
- MAX_TRIES, 64, number of candidates drawn before giving up; must be ≥ 1.
- CW, $clog2(MAX_TRIES+1), attempt counter width (derived, not overridable).

- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new selection; sampled only in IDLE.
- phi  in  WIDTH  totient; latched on accepted start.
- busy  out  1  high from the cycle after accepted start until the cycle done/fail is asserted (inclusive).
- done  out  1  one-cycle pulse; e_out valid.
- fail  out  1  one-cycle pulse; no coprime candidate within MAX_TRIES, or phi < 4.
- e_out  out  WIDTH  accepted exponent; held until the next accepted start.
- attempts  out  CW  candidates drawn in the current/last run; held after done/fail.
- rng_en  out  1  RNG advance enable.
- rng_data  in  WIDTH  RNG output; new value visible the cycle after rng_en.
- gcd_start  out  1  one-cycle pulse launching gcd.
- gcd_a  out  WIDTH  candidate; stable from gcd_start until gcd_done.
- gcd_b  out  WIDTH  latched phi; same stability.
- gcd_done  in  1  one-cycle pulse from gcd unit.
- gcd_result  in  WIDTH  gcd value, valid with gcd_done.

## Operation
- States: IDLE, DRAW, SAMPLE, CHECK, GCD_REQ, GCD_WAIT, FINISH.
- IDLE to DRAW on start; phi latched, attempts cleared.
- If latched phi < 4, go IDLE→FINISH with fail instead; no RNG or gcd activity.
- DRAW: rng_en = 1 for exactly one cycle; attempts += 1 → SAMPLE.
- SAMPLE: register rng_data into cand → CHECK.
- CHECK: cand is valid iff 3 ≤ cand < phi and cand odd (see Configuration).
  - Valid → GCD_REQ.
  - Invalid and attempts == MAX_TRIES → FINISH (fail).
  - Invalid otherwise → DRAW.
- GCD_REQ: gcd_start = 1 for one cycle, gcd_a = cand, gcd_b = phi → GCD_WAIT.
- GCD_WAIT: wait for gcd_done with no timeout.
  - gcd_result == 1 → FINISH (done), e_out ← cand.
  - Else if attempts == MAX_TRIES → FINISH (fail).
  - Else → DRAW.
- FINISH: done or fail pulsed for one cycle → IDLE.
- Compares are unsigned, WIDTH bits, with no wrap.
- Reset values: all outputs 0, e_out 0, attempts 0, state IDLE.
- Ignored inputs:
  - start outside IDLE, including the FINISH cycle.
  - gcd_done outside GCD_WAIT.
  - rng_data outside SAMPLE.
- Reset mid-run: next cycle is IDLE with rng_en, gcd_start, busy, done and fail all 0. An in-flight gcd_done after reset is ignored.

## Timing
- Accepted start at edge N: DRAW at N+1 (rng_en high), SAMPLE at N+2, CHECK at N+3, GCD_REQ at N+4 (gcd_start high).
- With gcd_done in cycle N+5: FINISH at N+6, so done is high in cycle N+6. This is the minimum latency.
- Each rejected-by-filter candidate costs 3 cycles (DRAW, SAMPLE, CHECK).
- Each gcd-rejected candidate costs 4 cycles plus the gcd latency.
- rng_en is never high on two consecutive cycles. gcd_start is never high while in GCD_WAIT.
- done and fail are mutually exclusive, and never both in the same run.

## Configuration
- PUBEXP_FORCE_ODD_EN defined: SAMPLE registers rng_data | 1, so even draws are forced odd rather than rejected. The range checks (≥ 3, < phi) are still applied to the forced value.
- Not defined: even candidates are rejected in CHECK and consume an attempt.

## Test plan
- phi = 4157295846, RNG mock sequence 10, 4157295900, 15 (gcd 3), 65537 (gcd 1) → done, e_out = 65537, attempts = 4, exactly one gcd_start per gcd candidate (2). With PUBEXP_FORCE_ODD_EN, 10 becomes 11; if the mock gcd returns 1 for 11 → e_out = 11, attempts = 1.
- phi = 3, start → fail in cycle N+1, rng_en and gcd_start never asserted, attempts = 0.
- MAX_TRIES = 4, mock gcd always returns 2 → fail after 4 rng_en pulses, attempts = 4, done never asserted.
- Mock gcd_done delayed 20 cycles → gcd_a and gcd_b stable throughout, and done exactly one cycle after gcd_done. A start pulse during the run is ignored.
- rst asserted in GCD_WAIT, then a stray gcd_done 2 cycles later → all outputs 0, state stays IDLE, no done.
- Minimum-latency check: gcd_done in N+5 → done in N+6, busy high N+1..N+6.
